// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator that serialises 16-bit register frames MSB-first and captures CIPO on reads.
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS,
    input  logic       CIPO
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam logic [7:0] HALF_END  = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_END = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_END  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_END   = 8'(CS_IDLE - 1);
    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d, rx, rx_d, rdata_d;
    logic [3:0]  bit_cnt, bit_cnt_d;
    logic [15:0] shreg, shreg_d;
    logic        sclk_d, copi_d, ncs_d, done_d;
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 8'd1;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        rx_d      = rx;
        rdata_d   = rdata;
        sclk_d    = SCLK;
        copi_d    = COPI;
        ncs_d     = nCS;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    state_d = SETUP;
                    shreg_d = {req_rw, req_addr, req_wdata};
                    ncs_d   = 1'b0;
                    copi_d  = req_rw;
                end
            end
            SETUP: if (cnt == SETUP_END) begin
                state_d   = SHIFT;
                cnt_d     = '0;
                bit_cnt_d = 4'd15;
            end
            // cnt counts one SCLK half-period; SCLK's current level says which half ends
            SHIFT: if (cnt == HALF_END) begin
                cnt_d  = '0;
                sclk_d = ~SCLK;
                if (!SCLK) begin
                    if (!bit_cnt[3]) rx_d = {rx[6:0], CIPO};
                end else if (bit_cnt == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    bit_cnt_d = bit_cnt - 4'd1;
                    shreg_d   = {shreg[14:0], 1'b0};
                    copi_d    = shreg[14];
                end
            end
            HOLD: if (cnt == HOLD_END) begin
                state_d = GAP;
                cnt_d   = '0;
                ncs_d   = 1'b1;
                copi_d  = 1'b0;
                done_d  = 1'b1;
                rdata_d = rx;
            end
            GAP: if (cnt == GAP_END) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            rx      <= '0;
            rdata   <= '0;
            SCLK    <= 1'b0;
            COPI    <= 1'b0;
            nCS     <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
            rx      <= rx_d;
            rdata   <= rdata_d;
            SCLK    <= sclk_d;
            COPI    <= copi_d;
            nCS     <= ncs_d;
            done    <= done_d;
        end
    end
endmodule
